i2s_tx_master: RTL and testbench
================================

// Module: i2s_tx_master
// PURPOSE
//  I2S (Philips) master transmitter for an I2S DAC/amp; playback counterpart of the INMP441 mic receiver.
//  Generates SCK/WS from CLOCK_50, serialises one stereo sample per frame MSB-first on SD.
//  Upstream logic pushes left/right sample pairs through a valid/ready handshake into a one-frame holding register.
// PARAMETERS
//  CLK_DIV   16  SCK half-period in CLOCK_50 cycles (>=2); default gives SCK = 1.5625 MHz.
//  SAMPLE_W  24  sample width in bits.
//  SLOT_W    32  SCK periods per channel slot; must satisfy SLOT_W >= SAMPLE_W+1.
// PORTS
//  CLOCK_50     in   1         system clock; all logic on its rising edge.
//  RESET        in   1         synchronous, active-high reset.
//  EN           in   1         1 = run SCK/WS/SD; 0 = idle (counters held at reset values, hold reg kept).
//  S_DATA_L     in   SAMPLE_W  left sample, two's complement.
//  S_DATA_R     in   SAMPLE_W  right sample.
//  S_VALID      in   1         sample pair valid.
//  S_READY      out  1         holding register empty; transfer when S_VALID & S_READY.
//  SCK          out  1         I2S bit clock (registered).
//  WS           out  1         word select: 0 = left slot, 1 = right slot (registered).
//  SD           out  1         serial data, changes on SCK falling edge (registered).
//  FRAME_START  out  1         1-cycle pulse when a new frame (left slot) begins.
//  UNDERFLOW    out  1         1-cycle pulse at frame start when no sample was held.
// BEHAVIOUR
//  Reset values: SCK=0, WS=0, SD=0, S_READY=1, FRAME_START=0, UNDERFLOW=0; frame regs = 0; hold empty.
//  Divider: div_cnt counts 0..CLK_DIV-1; on terminal count SCK toggles. SCK period = 2*CLK_DIV cycles.
//  "Fall event" = cycle where SCK toggles 1->0 (also the first toggle-to-low after reset, see below).
//  bit_cnt 0..2*SLOT_W-1, advances (with wrap) on each fall event; reset value 2*SLOT_W-1.
//   -> first fall event after reset/EN rise (2*CLK_DIV cycles after reset release) starts frame 0.
//  WS = (bit_cnt >= SLOT_W), updated with bit_cnt. b = bit_cnt mod SLOT_W.
//  SD = sample[SAMPLE_W-b] for 1<=b<=SAMPLE_W, else 0 (one-SCK I2S delay after WS edge; zero padding).
//  Frame start (fall event where bit_cnt wraps to 0): FRAME_START=1 that cycle;
//   hold full -> frame regs <= hold, hold empties (S_READY=1 next cycle);
//   hold empty -> UNDERFLOW=1, frame regs per CONFIGURATION.
//  Handshake: accept on S_VALID & S_READY -> hold full, S_READY=0 next cycle. S_READY is registered,
//   so accept and frame-start transfer in the same cycle cannot collide (S_READY=0 whenever hold full).
//  Max latency accept -> MSB on SD: one frame + 1 SCK period. S_DATA_* sampled only at accept.
//  Frame regs load at frame start only; a mid-frame accept never alters the frame in flight.
//  EN deassert: next cycle SCK=WS=SD=0, div_cnt/bit_cnt to reset values, current frame abandoned,
//   no UNDERFLOW; hold reg and handshake remain live. EN reassert restarts at frame 0 timing.
//  RESET mid-frame: next cycle all outputs at reset values, hold discarded, no pulses.
//  Default frame = 2*SLOT_W*2*CLK_DIV = 2048 CLOCK_50 cycles (24.414 kHz).
// CONFIGURATION
//  I2S_TX_HOLD_LAST_EN defined: on underflow frame regs keep previous sample (last pair repeats).
//  Not defined: on underflow frame regs cleared to 0 (silence). UNDERFLOW pulses in both cases.
// TESTING
//  1 Reset: RESET=1 for 5 cycles -> SCK=0,WS=0,SD=0,S_READY=1,FRAME_START=0,UNDERFLOW=0.
//  2 Single pair L=24'hA5A5A5 R=24'h5A5A5A pushed before frame 0 -> model sampling SD on SCK rise decodes
//    exact L/R; MSB one SCK after WS edge; bits 25..31 of each slot 0; WS period 2048 cycles.
//  3 Stream, S_VALID held 1, random data, 10 frames -> one accept per frame, no UNDERFLOW, all data exact.
//  4 No push for frame 1 after pair 24'h123456/24'hFEDCBA -> UNDERFLOW pulse at frame 1 start; SD all 0
//    (macro off) or 24'h123456/24'hFEDCBA repeated (I2S_TX_HOLD_LAST_EN on).
//  5 RESET at bit_cnt=20 of left slot with hold full -> next cycle outputs at reset values, S_READY=1,
//    next frame after release underflows.
//  6 CLK_DIV=2, SAMPLE_W=16, SLOT_W=16; EN toggled 0->1 -> SCK period 4 cycles, frame 128 cycles, data exact.

Source files
------------

// File: rtl/i2s_tx_master.sv
// i2s_tx_master
//   I2S (Philips format) master transmitter for a DAC or amplifier. It
//   derives SCK and WS from CLOCK_50 and shifts out one stereo pair per
//   frame, MSB first, one SCK after each WS edge. Upstream logic loads pairs
//   through a valid/ready handshake into a single-frame holding register.
//
// Parameters
//   CLK_DIV   SCK half-period in CLOCK_50 cycles (>= 2)
//   SAMPLE_W  sample width in bits
//   SLOT_W    SCK periods per channel slot (>= SAMPLE_W + 1)
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   RESET        in   synchronous active-high reset
//   EN           in   1 = run the serial interface, 0 = hold it idle
//   S_DATA_L/R   in   left/right sample, two's complement
//   S_VALID      in   sample pair valid
//   S_READY      out  holding register empty
//   SCK          out  bit clock
//   WS           out  word select, 0 = left slot, 1 = right slot
//   SD           out  serial data, changes as SCK falls
//   FRAME_START  out  one-cycle pulse as each frame's left slot begins
//   UNDERFLOW    out  one-cycle pulse at frame start when no pair was held
//
// Build option
//   I2S_TX_HOLD_LAST_EN  when defined, an underflow frame repeats the last
//                        pair; otherwise it transmits silence.

module i2s_tx_master #(
  parameter int CLK_DIV  = 16,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                EN,
  input  logic [SAMPLE_W-1:0] S_DATA_L,
  input  logic [SAMPLE_W-1:0] S_DATA_R,
  input  logic                S_VALID,
  output logic                S_READY,
  output logic                SCK,
  output logic                WS,
  output logic                SD,
  output logic                FRAME_START,
  output logic                UNDERFLOW
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(SAMPLE_W);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic                hold_full;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] frame_l, frame_r;

  logic                tick, fall, frame_start;
  logic [BIT_W-1:0]    bit_nxt, slot_bit;
  logic                right_nxt, sd_nxt;
  logic [SAMPLE_W-1:0] word;
  logic [IDX_W-1:0]    idx;

  // Everything below looks one fall event ahead: WS/SD are registered and
  // must present the bit that bit_cnt is about to move to.
  always_comb begin
    tick        = (div_cnt == DIV_LAST);
    fall        = tick && SCK;
    frame_start = fall && (bit_cnt == BIT_LAST);
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    right_nxt   = (bit_nxt >= SLOT_LEN);
    slot_bit    = right_nxt ? bit_nxt - SLOT_LEN : bit_nxt;
    word        = right_nxt ? frame_r : frame_l;
    idx         = '0;
    sd_nxt      = 1'b0;
    // Slot bit 0 is the I2S one-clock delay; bits past the sample are padding.
    if (slot_bit >= BIT_W'(1) && slot_bit <= DATA_LEN) begin
      idx    = IDX_W'(SAMPLE_W - int'(slot_bit));
      sd_nxt = word[idx];
    end
  end

  assign S_READY = ~hold_full;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      div_cnt     <= '0;
      bit_cnt     <= BIT_LAST;
      SCK         <= 1'b0;
      WS          <= 1'b0;
      SD          <= 1'b0;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      frame_l     <= '0;
      frame_r     <= '0;
    end else begin
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;

      // Accept and the frame-start drain are mutually exclusive: accept needs
      // the hold empty, the drain needs it full.
      if (S_VALID && !hold_full) begin
        hold_full <= 1'b1;
        hold_l    <= S_DATA_L;
        hold_r    <= S_DATA_R;
      end

      if (!EN) begin
        div_cnt <= '0;
        bit_cnt <= BIT_LAST;
        SCK     <= 1'b0;
        WS      <= 1'b0;
        SD      <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        SCK     <= ~SCK;
        if (fall) begin
          bit_cnt <= bit_nxt;
          WS      <= right_nxt;
          SD      <= sd_nxt;
        end
        if (frame_start) begin
          FRAME_START <= 1'b1;
          if (hold_full) begin
            frame_l   <= hold_l;
            frame_r   <= hold_r;
            hold_full <= 1'b0;
          end else begin
            UNDERFLOW <= 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
            frame_l <= frame_l;
            frame_r <= frame_r;
`else
            frame_l <= '0;
            frame_r <= '0;
`endif
          end
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: a default-parameter instance (d0) and a small
// instance (d1: CLK_DIV=2, SAMPLE_W=16, SLOT_W=16). The reference model
// derives every output from the number of enabled cycles since restart and
// the pairs handed over, and is compared on every cycle; directed checks with
// literal values pin the model.

module tb_i2s_tx_master;

  logic        clk;
  logic        rst0, en0, valid0;
  logic [23:0] dl0, dr0;
  logic        ready0, sck0, ws0, sd0, fs0, uf0;
  logic        rst1, en1, valid1;
  logic [15:0] dl1, dr1;
  logic        ready1, sck1, ws1, sd1, fs1, uf1;

  i2s_tx_master u_dut0 (
    .CLOCK_50(clk), .RESET(rst0), .EN(en0), .S_DATA_L(dl0), .S_DATA_R(dr0),
    .S_VALID(valid0), .S_READY(ready0), .SCK(sck0), .WS(ws0), .SD(sd0),
    .FRAME_START(fs0), .UNDERFLOW(uf0)
  );

  i2s_tx_master #(.CLK_DIV(2), .SAMPLE_W(16), .SLOT_W(16)) u_dut1 (
    .CLOCK_50(clk), .RESET(rst1), .EN(en1), .S_DATA_L(dl1), .S_DATA_R(dr1),
    .S_VALID(valid1), .S_READY(ready1), .SCK(sck1), .WS(ws1), .SD(sd1),
    .FRAME_START(fs1), .UNDERFLOW(uf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int cd(input int d); return (d == 0) ? 16 : 2;  endfunction
  function automatic int sw(input int d); return (d == 0) ? 24 : 16; endfunction
  function automatic int sl(input int d); return (d == 0) ? 32 : 16; endfunction

  // Model state per instance.
  int          n [2];
  bit          m_full [2];
  logic [23:0] m_hl [2], m_hr [2], m_fl [2], m_fr [2];
  bit          m_fs [2], m_uf [2], m_acc [2];
  int          acc_cnt0 = 0;

  task automatic model_step(input int d, input bit r, input bit e, input bit v,
                            input logic [23:0] l, input logic [23:0] rr);
    bit was_full;
    int p;
    was_full = m_full[d];
    m_fs[d] = 0; m_uf[d] = 0; m_acc[d] = 0;
    if (r) begin
      n[d] = 0; m_full[d] = 0; m_fl[d] = '0; m_fr[d] = '0;
    end else begin
      if (!e) n[d] = 0;
      else begin
        n[d]++;
        if (n[d] % (2 * cd(d)) == 0) begin
          p = n[d] / (2 * cd(d));
          if ((p - 1) % (2 * sl(d)) == 0) begin
            m_fs[d] = 1;
            if (was_full) begin
              m_fl[d] = m_hl[d]; m_fr[d] = m_hr[d]; m_full[d] = 0;
            end else begin
              m_uf[d] = 1;
`ifndef I2S_TX_HOLD_LAST_EN
              m_fl[d] = '0; m_fr[d] = '0;
`endif
            end
          end
        end
      end
      if (v && !was_full) begin
        m_hl[d] = l; m_hr[d] = rr; m_full[d] = 1; m_acc[d] = 1;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; m_full[d] = 0; m_hl[d] = '0; m_hr[d] = '0;
      m_fl[d] = '0; m_fr[d] = '0; m_fs[d] = 0; m_uf[d] = 0; m_acc[d] = 0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    model_step(0, rst0, en0, valid0, dl0, dr0);
    model_step(1, rst1, en1, valid1, {8'h00, dl1}, {8'h00, dr1});
    if (m_acc[0]) acc_cnt0++;
  end

  task automatic cmp_dut(input int d, input logic a_sck, input logic a_ws, input logic a_sd,
                         input logic a_fs, input logic a_uf, input logic a_rdy);
    int p, pos, b;
    logic e_ws, e_sd;
    logic [23:0] w;
    p = n[d] / (2 * cd(d));
    e_ws = 1'b0; e_sd = 1'b0;
    if (p > 0) begin
      pos  = (p - 1) % (2 * sl(d));
      e_ws = (pos >= sl(d));
      b    = pos % sl(d);
      w    = e_ws ? m_fr[d] : m_fl[d];
      if (b >= 1 && b <= sw(d)) e_sd = w[sw(d) - b];
    end
    chk($sformatf("d%0d_sck", d), 48'(a_sck), 48'((n[d] / cd(d)) % 2));
    chk($sformatf("d%0d_ws", d), 48'(a_ws), 48'(e_ws));
    chk($sformatf("d%0d_sd", d), 48'(a_sd), 48'(e_sd));
    chk($sformatf("d%0d_frame_start", d), 48'(a_fs), 48'(m_fs[d]));
    chk($sformatf("d%0d_underflow", d), 48'(a_uf), 48'(m_uf[d]));
    chk($sformatf("d%0d_ready", d), 48'(a_rdy), 48'(!m_full[d]));
  endtask

  // Independent SD decoder for d0, sampling on SCK rise, plus edge stamps.
  bit          armed = 0;
  int          k = 0, b0;
  logic [23:0] dw = '0, cur_l = '0;
  logic [47:0] dq [$];
  bit          sck0_prev = 0, ws0_prev = 0, sck1_prev = 0, ws1_prev = 0;
  int          ws0_rise [$], ws1_rise [$], sck1_rise [$];
  int          fs_cnt0 = 0, uf_cnt0 = 0, uf_cnt1 = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut(0, sck0, ws0, sd0, fs0, uf0, ready0);
      cmp_dut(1, sck1, ws1, sd1, fs1, uf1, ready1);
    end
    if (rst0 || !en0) armed = 0;
    else if (fs0) begin
      armed = 1; k = 0;
    end else if (armed && sck0 && !sck0_prev) begin
      b0 = k % 32;
      if (b0 >= 1 && b0 <= 24) dw = {dw[22:0], sd0};
      if (b0 == 24) begin
        if (k < 32) cur_l = dw;
        else dq.push_back({cur_l, dw});
      end
      k = (k + 1) % 64;
    end
    if (ws0 && !ws0_prev) ws0_rise.push_back(cyc);
    if (ws1 && !ws1_prev) ws1_rise.push_back(cyc);
    if (sck1 && !sck1_prev) sck1_rise.push_back(cyc);
    sck0_prev = sck0; ws0_prev = ws0; sck1_prev = sck1; ws1_prev = ws1;
    if (fs0 === 1'b1) fs_cnt0++;
    if (uf0 === 1'b1) uf_cnt0++;
    if (uf1 === 1'b1) uf_cnt1++;
  end

  task automatic tick(input int c);
    repeat (c) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_fs(input int d, input int maxc, output int took);
    took = 0;
    while (took < maxc) begin
      tick(1);
      took++;
      if ((d == 0 && fs0 === 1'b1) || (d == 1 && fs1 === 1'b1)) return;
    end
    chk($sformatf("d%0d_frame_start_timeout", d), 48'(took), 48'(maxc + 1));
  endtask

  task automatic clear_logs();
    dq.delete(); ws0_rise.delete(); ws1_rise.delete(); sck1_rise.delete();
    fs_cnt0 = 0; uf_cnt0 = 0; uf_cnt1 = 0; acc_cnt0 = 0;
  endtask

  task automatic restart0();
    rst0 = 1; en0 = 1; valid0 = 0;
    tick(3);
    clear_logs();
  endtask

  logic [47:0] sent [$];
  int took, guard;
  logic [47:0] exp_rep;

  initial begin
    rst0 = 1; en0 = 0; valid0 = 0; dl0 = '0; dr0 = '0;
    rst1 = 1; en1 = 0; valid1 = 0; dl1 = '0; dr1 = '0;
    tick(2);
    chk_on = 1;

    // 1: reset values
    tick(5);
    chk("rst_sck", 48'(sck0), 48'h0);
    chk("rst_ws", 48'(ws0), 48'h0);
    chk("rst_sd", 48'(sd0), 48'h0);
    chk("rst_ready", 48'(ready0), 48'h1);
    chk("rst_frame_start", 48'(fs0), 48'h0);
    chk("rst_underflow", 48'(uf0), 48'h0);

    // 2: one pair before frame 0
    clear_logs();
    rst0 = 0; en0 = 1; valid0 = 1; dl0 = 24'hA5A5A5; dr0 = 24'h5A5A5A;
    tick(1);
    valid0 = 0;
    wait_fs(0, 100, took);
    chk("t2_first_frame_latency", 48'(took + 1), 48'd32);
    tick(2 * 2048);
    chk("t2_frames_decoded", 48'(dq.size() >= 2), 48'h1);
    if (dq.size() >= 2) begin
      chk("t2_pair", dq[0], 48'hA5A5A5_5A5A5A);
      chk("t2_underflow_pair", dq[1], 48'h0);
    end
    chk("t2_ws_rises", 48'(ws0_rise.size() >= 2), 48'h1);
    if (ws0_rise.size() >= 2)
      chk("t2_ws_period", 48'(ws0_rise[1] - ws0_rise[0]), 48'd2048);

    // 4: underflow on frame 1
    restart0();
    rst0 = 0; valid0 = 1; dl0 = 24'h123456; dr0 = 24'hFEDCBA;
    tick(1);
    valid0 = 0;
    tick(31 + 2048 + 4);
    chk("t4_underflow_count", 48'(uf_cnt0), 48'd1);
    chk("t4_frame_count", 48'(fs_cnt0), 48'd2);
    tick(2048);
`ifdef I2S_TX_HOLD_LAST_EN
    exp_rep = 48'h123456_FEDCBA;
`else
    exp_rep = 48'h0;
`endif
    chk("t4_frames_decoded", 48'(dq.size() >= 2), 48'h1);
    if (dq.size() >= 2) begin
      chk("t4_frame0", dq[0], 48'h123456_FEDCBA);
      chk("t4_frame1", dq[1], exp_rep);
    end

    // 3: streaming, S_VALID held high
    restart0();
    sent.delete();
    rst0 = 0; valid0 = 1; dl0 = 24'($urandom); dr0 = 24'($urandom);
    for (int c = 0; c < 32 + 10 * 2048 - 10; c++) begin
      tick(1);
      if (m_acc[0]) begin
        sent.push_back({dl0, dr0});
        dl0 = 24'($urandom); dr0 = 24'($urandom);
      end
    end
    valid0 = 0;
    chk("t3_accepts", 48'(acc_cnt0), 48'd11);
    chk("t3_frames", 48'(fs_cnt0), 48'd10);
    chk("t3_underflows", 48'(uf_cnt0), 48'd0);
    chk("t3_frames_decoded", 48'(dq.size()), 48'd10);
    for (int i = 0; i < 10; i++)
      if (i < dq.size() && i < sent.size())
        chk($sformatf("t3_frame%0d", i), dq[i], sent[i]);

    // 5: reset mid left slot with hold full
    restart0();
    rst0 = 0; valid0 = 1; dl0 = 24'h111111; dr0 = 24'h222222;
    tick(1);
    valid0 = 0;
    wait_fs(0, 100, took);
    valid0 = 1; dl0 = 24'h333333; dr0 = 24'h444444;
    tick(1);
    valid0 = 0;
    guard = 0;
    while (n[0] < 32 + 20 * 32 + 5 && guard < 2000) begin
      tick(1);
      guard++;
    end
    chk("t5_hold_full_before_reset", 48'(ready0), 48'h0);
    rst0 = 1;
    tick(1);
    chk("t5_sck", 48'(sck0), 48'h0);
    chk("t5_ws", 48'(ws0), 48'h0);
    chk("t5_sd", 48'(sd0), 48'h0);
    chk("t5_ready", 48'(ready0), 48'h1);
    chk("t5_frame_start", 48'(fs0), 48'h0);
    chk("t5_underflow", 48'(uf0), 48'h0);
    rst0 = 0;
    uf_cnt0 = 0;
    tick(40);
    chk("t5_underflow_after_release", 48'(uf_cnt0), 48'd1);

    // 6: small instance, EN-driven start
    rst0 = 1; en0 = 0;
    rst1 = 0; en1 = 0;
    tick(3);
    valid1 = 1; dl1 = 16'hBEEF; dr1 = 16'h1234;
    tick(1);
    valid1 = 0;
    chk("t6_accept_while_idle", 48'(ready1), 48'h0);
    clear_logs();
    en1 = 1;
    wait_fs(1, 20, took);
    chk("t6_first_frame_latency", 48'(took), 48'd4);
    valid1 = 1; dl1 = 16'hC3A5; dr1 = 16'h0F0F;
    tick(1);
    valid1 = 0;
    tick(300);
    chk("t6_sck_rises", 48'(sck1_rise.size() >= 2), 48'h1);
    if (sck1_rise.size() >= 2)
      chk("t6_sck_period", 48'(sck1_rise[1] - sck1_rise[0]), 48'd4);
    chk("t6_ws_rises", 48'(ws1_rise.size() >= 2), 48'h1);
    if (ws1_rise.size() >= 2)
      chk("t6_frame_period", 48'(ws1_rise[1] - ws1_rise[0]), 48'd128);
    valid1 = 1; dl1 = 16'h8001; dr1 = 16'h7FFE;
    tick(1);
    valid1 = 0;
    tick(30);
    en1 = 0;
    uf_cnt1 = 0;
    tick(1);
    chk("t6_off_sck", 48'(sck1), 48'h0);
    chk("t6_off_ws", 48'(ws1), 48'h0);
    chk("t6_off_sd", 48'(sd1), 48'h0);
    tick(200);
    chk("t6_off_underflow", 48'(uf_cnt1), 48'd0);
    en1 = 1;
    tick(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
